// File: rtl/boundary_param_sequencer.sv
// Per-frame rotation-coefficient sequencer: captures start/end points, drives the shared
// divider, arctan and sin/cos LUTs, and publishes results atomically on frame_start.
module boundary_param_sequencer #(
  parameter int DIV_LATENCY = 4,
  parameter int LUT_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [17:0]        SW,
  input  logic [10:0]        end_x,
  input  logic [10:0]        end_y,
  output logic               div_start,
  output logic signed [11:0] div_numer,
  output logic signed [11:0] div_denom,
  input  logic signed [11:0] div_quotient,
  input  logic signed [11:0] div_remainder,
  output logic [11:0]        atan_abs_q,
  output logic signed [11:0] atan_rem,
  output logic               atan_sign_x,
  output logic               atan_sign_y,
  input  logic signed [9:0]  atan_theta,
  output logic signed [9:0]  trig_theta,
  input  logic signed [19:0] cos_in,
  input  logic signed [19:0] sin_in,
  output logic signed [19:0] cos_coef,
  output logic signed [19:0] sin_coef,
  output logic [10:0]        origin_x,
  output logic [10:0]        origin_y,
  output logic               params_valid,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DIV,
    ATAN,
    TRIG,
    DONE
  } state_t;

  localparam int CNT_MAX = (DIV_LATENCY > LUT_LATENCY) ? DIV_LATENCY : LUT_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic signed [19:0] COEF_ONE  = 20'sh00100;
  localparam logic signed [9:0]  THETA_P90 = 10'sd90;
  localparam logic signed [9:0]  THETA_M90 = -10'sd90;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [10:0]        start_x;
  logic [10:0]        start_y;
  logic signed [19:0] shadow_cos;
  logic signed [19:0] shadow_sin;
  logic [10:0]        shadow_origin_x;
  logic [10:0]        shadow_origin_y;
  logic               shadow_ready;

  logic               dx_zero;
  logic               div_last;
  logic               atan_last;
  logic               trig_last;
  logic               publish;
  logic signed [9:0]  forced_theta;

  assign dx_zero   = (div_denom == 12'sd0);
  // A vertical line skips the divider but spends an extra DIV cycle so the forced angle
  // is registered onto trig_theta before TRIG starts counting LUT latency.
  assign div_last  = (state == DIV) &&
                     (dx_zero ? (cnt == CNT_W'(1)) : (cnt == CNT_W'(DIV_LATENCY)));
  assign atan_last = (state == ATAN) && (cnt == CNT_W'(LUT_LATENCY - 1));
  assign trig_last = (state == TRIG) && (cnt == CNT_W'(LUT_LATENCY - 1));
  assign publish   = frame_start && (((state == IDLE) && shadow_ready) || (state == DONE));

  always_comb begin
    forced_theta = 10'sd0;
    if (div_numer != 12'sd0) begin
      forced_theta = div_numer[11] ? THETA_M90 : THETA_P90;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // frame_start always restarts at CAPTURE, whether from IDLE, DONE or mid-sequence
  always_comb begin
    next_state = state;
    if (frame_start) begin
      next_state = CAPTURE;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        CAPTURE: next_state = DIV;
        DIV:     if (div_last) next_state = dx_zero ? TRIG : ATAN;
        ATAN:    if (atan_last) next_state = TRIG;
        TRIG:    if (trig_last) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    div_start = (state == DIV) && !dx_zero && (cnt == '0);
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cos_coef        <= COEF_ONE;
      sin_coef        <= '0;
      origin_x        <= '0;
      origin_y        <= '0;
      params_valid    <= 1'b0;
      shadow_ready    <= 1'b0;
      overrun         <= 1'b0;
      start_x         <= '0;
      start_y         <= '0;
      div_numer       <= '0;
      div_denom       <= '0;
      atan_abs_q      <= '0;
      atan_rem        <= '0;
      atan_sign_x     <= 1'b0;
      atan_sign_y     <= 1'b0;
      trig_theta      <= '0;
      shadow_cos      <= COEF_ONE;
      shadow_sin      <= '0;
      shadow_origin_x <= '0;
      shadow_origin_y <= '0;
    end else begin
      overrun <= frame_start && busy;

      if (publish) begin
        cos_coef     <= shadow_cos;
        sin_coef     <= shadow_sin;
        origin_x     <= shadow_origin_x;
        origin_y     <= shadow_origin_y;
        params_valid <= 1'b1;
        shadow_ready <= 1'b0;
      end else if (state == DONE) begin
        shadow_ready <= 1'b1;
      end

      // Offsets wrap mod 2^12; the divider sees them as signed dy / dx
      if (state == CAPTURE) begin
        start_x   <= SW[17:7];
        start_y   <= {SW[6:2], 6'd0};
        div_denom <= {1'b0, end_x} - {1'b0, SW[17:7]};
        div_numer <= {1'b0, end_y} - {1'b0, SW[6:2], 6'd0};
      end

      if ((state == DIV) && dx_zero && (cnt == '0)) begin
        trig_theta <= forced_theta;
      end

      if (div_last && !dx_zero) begin
        atan_abs_q  <= div_quotient[11] ? $unsigned(-div_quotient) : $unsigned(div_quotient);
        atan_rem    <= div_remainder;
        atan_sign_x <= div_denom[11];
        atan_sign_y <= div_numer[11];
      end

      if (atan_last) begin
        trig_theta <= atan_theta;
      end

      if (trig_last) begin
        shadow_cos      <= cos_in;
        shadow_sin      <= sin_in;
        shadow_origin_x <= start_x;
        shadow_origin_y <= start_y;
      end
    end
  end

endmodule

// File: tb/tb_boundary_param_sequencer.sv
// Directed bench for boundary_param_sequencer with simple combinational divider/LUT models.
module tb_boundary_param_sequencer;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [17:0] SW;
  logic [10:0] end_x;
  logic [10:0] end_y;
  logic        div_start;
  logic [11:0] div_numer;
  logic [11:0] div_denom;
  logic [11:0] div_quotient;
  logic [11:0] div_remainder;
  logic [11:0] atan_abs_q;
  logic [11:0] atan_rem;
  logic        atan_sign_x;
  logic        atan_sign_y;
  logic [9:0]  atan_theta;
  logic [9:0]  trig_theta;
  logic [19:0] cos_in;
  logic [19:0] sin_in;
  logic [19:0] cos_coef;
  logic [19:0] sin_coef;
  logic [10:0] origin_x;
  logic [10:0] origin_y;
  logic        params_valid;
  logic        busy;
  logic        done;
  logic        overrun;

  int total_checks;
  int bad_checks;
  int ds_cycle;
  int ds_count;
  int done_cycle;
  int done_count;
  int busy_count;

  boundary_param_sequencer #(.DIV_LATENCY(4), .LUT_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .SW(SW),
    .end_x(end_x), .end_y(end_y), .div_start(div_start),
    .div_numer(div_numer), .div_denom(div_denom),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .atan_abs_q(atan_abs_q), .atan_rem(atan_rem),
    .atan_sign_x(atan_sign_x), .atan_sign_y(atan_sign_y),
    .atan_theta(atan_theta), .trig_theta(trig_theta),
    .cos_in(cos_in), .sin_in(sin_in), .cos_coef(cos_coef), .sin_coef(sin_coef),
    .origin_x(origin_x), .origin_y(origin_y), .params_valid(params_valid),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    div_quotient  = '0;
    div_remainder = '0;
    if (div_denom != 12'd0) begin
      div_quotient  = $signed(div_numer) / $signed(div_denom);
      div_remainder = $signed(div_numer) % $signed(div_denom);
    end
  end

  always_comb begin
    atan_theta = 10'd0;
    if (atan_abs_q == 12'd1) atan_theta = 10'd45;
    else if (atan_abs_q == 12'd2) atan_theta = 10'd63;
  end

  always_comb begin
    cos_in = 20'h00080;
    sin_in = 20'h00080;
    case (trig_theta)
      10'd45:  begin cos_in = 20'h000B5; sin_in = 20'h000B5; end
      10'd0:   begin cos_in = 20'h00100; sin_in = 20'h00000; end
      10'h3A6: begin cos_in = 20'h00000; sin_in = 20'hFFF00; end
      default: begin cos_in = 20'h00080; sin_in = 20'h00080; end
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame_start pulse; on return the DUT is in cycle 1 of the new sequence
  task automatic applyStimulus(input logic [17:0] sw_v, input logic [10:0] ex,
                               input logic [10:0] ey);
    SW          = sw_v;
    end_x       = ex;
    end_y       = ey;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic watch(input int first_c, input int n);
    ds_cycle   = 0;
    ds_count   = 0;
    done_cycle = 0;
    done_count = 0;
    for (int c = first_c; c < first_c + n; c++) begin
      if (div_start) begin
        ds_count++;
        if (ds_cycle == 0) ds_cycle = c;
      end
      if (done) begin
        done_count++;
        if (done_cycle == 0) done_cycle = c;
      end
      step();
    end
  endtask

  initial begin
    clk          = 1'b0;
    reset        = 1'b0;
    frame_start  = 1'b0;
    SW           = '0;
    end_x        = '0;
    end_y        = '0;
    total_checks = 0;
    bad_checks   = 0;

    repeat (3) step();
    reset = 1'b1;
    checkOutput("rst_cos", cos_coef, 32'h00100);
    checkOutput("rst_sin", sin_coef, 32'h0);
    checkOutput("rst_origin", {origin_x, origin_y}, 32'h0);
    checkOutput("rst_valid", params_valid, 32'h0);
    checkOutput("rst_flags", {busy, done, overrun, div_start}, 32'h0);
    busy_count = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_count++;
      step();
    end
    checkOutput("idle_busy", busy_count, 32'd0);
    checkOutput("idle_valid", params_valid, 32'h0);

    // Diagonal 45 degree line, then a second frame publishes it
    applyStimulus(18'd0, 11'd100, 11'd100);
    checkOutput("a_busy_rise", busy, 32'h1);
    watch(1, 12);
    checkOutput("a_ds_cycle", ds_cycle, 32'd2);
    checkOutput("a_ds_count", ds_count, 32'd1);
    checkOutput("a_done_cycle", done_cycle, 32'd9);
    checkOutput("a_done_count", done_count, 32'd1);
    checkOutput("a_busy_fall", busy, 32'h0);
    checkOutput("a_unpub_cos", cos_coef, 32'h00100);
    checkOutput("a_unpub_valid", params_valid, 32'h0);
    checkOutput("a_abs_q", atan_abs_q, 32'd1);
    checkOutput("a_theta", trig_theta, 32'd45);
    applyStimulus(18'd0, 11'd100, 11'd100);
    checkOutput("a_pub_cos", cos_coef, 32'h000B5);
    checkOutput("a_pub_sin", sin_coef, 32'h000B5);
    checkOutput("a_pub_valid", params_valid, 32'h1);
    watch(1, 12);

    // Vertical line going up: forced -90, no divider launch
    applyStimulus({11'd64, 5'd1, 2'b00}, 11'd64, 11'd0);
    watch(1, 10);
    checkOutput("b_ds_count", ds_count, 32'd0);
    checkOutput("b_done_cycle", done_cycle, 32'd5);
    checkOutput("b_theta", trig_theta, 32'h3A6);
    applyStimulus({11'd64, 5'd1, 2'b00}, 11'd64, 11'd0);
    checkOutput("b_pub_cos", cos_coef, 32'h0);
    checkOutput("b_pub_sin", sin_coef, 32'hFFF00);
    checkOutput("b_pub_origin", {origin_x, origin_y}, {10'd0, 11'd64, 11'd64});
    watch(1, 10);

    // Start equals end
    applyStimulus({11'd200, 5'd2, 2'b00}, 11'd200, 11'd128);
    watch(1, 10);
    checkOutput("c_ds_count", ds_count, 32'd0);
    checkOutput("c_done_cycle", done_cycle, 32'd5);
    checkOutput("c_theta", trig_theta, 32'h0);

    // frame_start at cycle 4 restarts the sequence without publishing
    applyStimulus(18'd0, 11'd100, 11'd100);
    checkOutput("o_pub_origin", {origin_x, origin_y}, {10'd0, 11'd200, 11'd128});
    watch(1, 3);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    checkOutput("o_overrun", overrun, 32'h1);
    checkOutput("o_nopub_origin", origin_x, 32'd200);
    watch(5, 12);
    checkOutput("o_overrun_fall", overrun, 32'h0);
    checkOutput("o_ds_cycle", ds_cycle, 32'd6);
    checkOutput("o_done_cycle", done_cycle, 32'd13);

    // Negative slope: quotient -2
    applyStimulus({11'd0, 5'd1, 2'b00}, 11'd32, 11'd0);
    checkOutput("d_pub_cos", cos_coef, 32'h000B5);
    watch(1, 12);
    checkOutput("d_abs_q", atan_abs_q, 32'd2);
    checkOutput("d_signs", {atan_sign_x, atan_sign_y}, 32'b01);
    checkOutput("d_rem", atan_rem, 32'h0);
    checkOutput("d_theta", trig_theta, 32'd63);
    checkOutput("d_done_cycle", done_cycle, 32'd9);

    // Reset during ATAN aborts and clears published state
    applyStimulus(18'd0, 11'd100, 11'd100);
    checkOutput("r_pub_cos", cos_coef, 32'h00080);
    watch(1, 6);
    checkOutput("r_busy_atan", busy, 32'h1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    checkOutput("r_busy", busy, 32'h0);
    checkOutput("r_cos", cos_coef, 32'h00100);
    checkOutput("r_valid", params_valid, 32'h0);
    checkOutput("r_theta", trig_theta, 32'h0);
    checkOutput("r_abs_q", atan_abs_q, 32'h0);
    watch(1, 12);
    checkOutput("r_no_done", done_count, 32'd0);
    applyStimulus(18'd0, 11'd100, 11'd100);
    checkOutput("r_no_pub", params_valid, 32'h0);
    watch(1, 12);
    checkOutput("r_done_cycle", done_cycle, 32'd9);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
